// File: rtl/pipeline_processor_core_if.sv
// Result bus of the pipeline core: the most recent non-r0 write-back value.
interface pipeline_processor_core_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] result;

    modport master (output result);
    modport slave  (input  result);
endinterface

// File: rtl/pipeline_processor_core.sv
// Four-stage in-order core (IF, ID, EX, WB) running a fixed ROM program on an
// 8-entry register file; the last register write-back is exposed on the bus.
module pipeline_processor_core #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ROM_DEPTH = 16,
    parameter logic [16*ROM_DEPTH-1:0] ROM_IMAGE = {
        {(16*(ROM_DEPTH-7)){1'b0}},
        16'h4E50,   // 6 OR   r7,r1,r2
        16'h3CD0,   // 5 AND  r6,r3,r2
        16'h5AD0,   // 4 XOR  r5,r3,r2
        16'h28C8,   // 3 SUB  r4,r3,r1
        16'h1650,   // 2 ADD  r3,r1,r2
        16'h640A,   // 1 ADDI r2,r0,10
        16'h6205    // 0 ADDI r1,r0,5
    }
) (
    input  logic                       clk,
    input  logic                       reset,
    pipeline_processor_core_if.master  bus
);
    localparam int unsigned PC_W = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

    typedef enum logic [2:0] {
        ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_ADDI
    } alu_op_e;

    logic [PC_W-1:0]   pc_q,        pc_d;
    logic [15:0]       ifid_instr_q, ifid_instr_d;
    alu_op_e           idex_op_q,   idex_op_d;
    logic [2:0]        idex_rd_q,   idex_rd_d;
    logic [2:0]        idex_rs1_q,  idex_rs1_d;
    logic [2:0]        idex_rs2_q,  idex_rs2_d;
    logic [DATA_W-1:0] idex_a_q,    idex_a_d;
    logic [DATA_W-1:0] idex_b_q,    idex_b_d;
    logic [DATA_W-1:0] idex_imm_q,  idex_imm_d;
    logic              wb_we_q,     wb_we_d;
    logic [2:0]        wb_rd_q,     wb_rd_d;
    logic [DATA_W-1:0] wb_val_q,    wb_val_d;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] regs_q [8];

    logic [2:0]        id_rs1, id_rs2;
    logic [DATA_W-1:0] ex_a, ex_b;

    always_comb begin
        pc_d         = (pc_q == PC_W'(ROM_DEPTH - 1)) ? '0 : pc_q + PC_W'(1);
        ifid_instr_d = ROM_IMAGE[16*int'(pc_q) +: 16];

        case (ifid_instr_q[15:12])
            4'd1:    idex_op_d = ALU_ADD;
            4'd2:    idex_op_d = ALU_SUB;
            4'd3:    idex_op_d = ALU_AND;
            4'd4:    idex_op_d = ALU_OR;
            4'd5:    idex_op_d = ALU_XOR;
            4'd6:    idex_op_d = ALU_ADDI;
            default: idex_op_d = ALU_NOP;
        endcase
        id_rs1     = ifid_instr_q[8:6];
        id_rs2     = ifid_instr_q[5:3];
        idex_rd_d  = ifid_instr_q[11:9];
        idex_rs1_d = id_rs1;
        idex_rs2_d = id_rs2;
        idex_imm_d = {{(DATA_W-6){ifid_instr_q[5]}}, ifid_instr_q[5:0]};

        // Register read with bypass of the write retiring on this same edge.
        if (id_rs1 == 3'd0)                        idex_a_d = '0;
        else if (wb_we_q && (wb_rd_q == id_rs1))   idex_a_d = wb_val_q;
        else                                       idex_a_d = regs_q[id_rs1];
        if (id_rs2 == 3'd0)                        idex_b_d = '0;
        else if (wb_we_q && (wb_rd_q == id_rs2))   idex_b_d = wb_val_q;
        else                                       idex_b_d = regs_q[id_rs2];

        // wb_we_q implies wb_rd_q != 0, so r0 sources never match a forward.
        ex_a = (wb_we_q && (wb_rd_q == idex_rs1_q)) ? wb_val_q : idex_a_q;
        ex_b = (wb_we_q && (wb_rd_q == idex_rs2_q)) ? wb_val_q : idex_b_q;
        if (idex_op_q == ALU_ADDI) ex_b = idex_imm_q;

        case (idex_op_q)
            ALU_ADD, ALU_ADDI: wb_val_d = ex_a + ex_b;
            ALU_SUB:           wb_val_d = ex_a - ex_b;
            ALU_AND:           wb_val_d = ex_a & ex_b;
            ALU_OR:            wb_val_d = ex_a | ex_b;
            ALU_XOR:           wb_val_d = ex_a ^ ex_b;
            default:           wb_val_d = '0;
        endcase
        wb_we_d = (idex_op_q != ALU_NOP) && (idex_rd_q != 3'd0);
        wb_rd_d = idex_rd_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q         <= '0;
            ifid_instr_q <= '0;
            idex_op_q    <= ALU_NOP;
            idex_rd_q    <= '0;
            idex_rs1_q   <= '0;
            idex_rs2_q   <= '0;
            idex_a_q     <= '0;
            idex_b_q     <= '0;
            idex_imm_q   <= '0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_val_q     <= '0;
            result_q     <= '0;
            for (int unsigned i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            idex_op_q    <= idex_op_d;
            idex_rd_q    <= idex_rd_d;
            idex_rs1_q   <= idex_rs1_d;
            idex_rs2_q   <= idex_rs2_d;
            idex_a_q     <= idex_a_d;
            idex_b_q     <= idex_b_d;
            idex_imm_q   <= idex_imm_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_val_q     <= wb_val_d;
            if (wb_we_q) begin
                regs_q[wb_rd_q] <= wb_val_q;
                result_q        <= wb_val_q;
            end
        end
    end

    assign bus.result = result_q;
endmodule

// File: tb/tb_pipeline_processor_core.sv
// Bench for pipeline_processor_core: four ROM images checked every cycle against
// an architectural (one instruction at a time) model, plus literal expectations.
module tb_pipeline_processor_core;
    localparam logic [255:0] ROM0 = {144'h0, 16'h4E50, 16'h3CD0, 16'h5AD0,
                                     16'h28C8, 16'h1650, 16'h640A, 16'h6205};
    localparam logic [255:0] ROM1 = {224'h0, 16'h1248, 16'h623F};
    localparam logic [255:0] ROM2 = {240'h0, 16'h6007};
    localparam logic [255:0] ROM3 = {16'h669F, 16'h5248, 16'hF2FF, 16'h14B8,
                                     16'h1490, 16'h6DA0, 16'h2E30, 16'h9E48,
                                     16'h11B0, 16'h4D60, 16'h3B08, 16'h5858,
                                     16'h22D0, 16'h1650, 16'h6451, 16'h623D};

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    logic done = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipeline_processor_core_if #(.DATA_W(32)) bus0 ();
    pipeline_processor_core_if #(.DATA_W(32)) bus1 ();
    pipeline_processor_core_if #(.DATA_W(32)) bus2 ();
    pipeline_processor_core_if #(.DATA_W(32)) bus3 ();

    pipeline_processor_core #(.DATA_W(32), .ROM_DEPTH(16))
        dut0 (.clk(clk), .reset(rst_a), .bus(bus0));
    pipeline_processor_core #(.DATA_W(32), .ROM_DEPTH(16), .ROM_IMAGE(ROM1))
        dut1 (.clk(clk), .reset(rst_a), .bus(bus1));
    pipeline_processor_core #(.DATA_W(32), .ROM_DEPTH(16), .ROM_IMAGE(ROM2))
        dut2 (.clk(clk), .reset(rst_a), .bus(bus2));
    pipeline_processor_core #(.DATA_W(32), .ROM_DEPTH(16), .ROM_IMAGE(ROM3))
        dut3 (.clk(clk), .reset(rst_b), .bus(bus3));

    // Architectural model: instruction k (0-based since release) retires on edge k+4.
    logic [31:0] mreg [4][8];
    logic [31:0] mres [4];
    int          medges [4];

    function automatic logic [15:0] rom_word(int inst, int idx);
        logic [255:0] img;
        case (inst)
            0:       img = ROM0;
            1:       img = ROM1;
            2:       img = ROM2;
            default: img = ROM3;
        endcase
        return img[idx*16 +: 16];
    endfunction

    function automatic logic [31:0] dut_res(int inst);
        case (inst)
            0:       return bus0.result;
            1:       return bus1.result;
            2:       return bus2.result;
            default: return bus3.result;
        endcase
    endfunction

    task automatic model_reset(int inst);
        for (int r = 0; r < 8; r++) mreg[inst][r] = 32'h0;
        mres[inst]   = 32'h0;
        medges[inst] = 0;
    endtask

    task automatic model_edge(int inst);
        logic [15:0] w;
        logic [31:0] a, b, v;
        int          op;
        medges[inst]++;
        if (medges[inst] >= 4) begin
            w  = rom_word(inst, (medges[inst] - 4) % 16);
            op = int'(w[15:12]);
            a  = mreg[inst][w[8:6]];
            b  = mreg[inst][w[5:3]];
            case (op)
                1: v = a + b;
                2: v = a - b;
                3: v = a & b;
                4: v = a | b;
                5: v = a ^ b;
                6: v = a + {{26{w[5]}}, w[5:0]};
                default: v = 32'h0;
            endcase
            if (op >= 1 && op <= 6 && w[11:9] != 3'd0) begin
                mreg[inst][w[11:9]] = v;
                mres[inst] = v;
            end
        end
    endtask

    initial for (int i = 0; i < 4; i++) model_reset(i);

    always @(negedge rst_a) for (int i = 0; i < 3; i++) model_reset(i);
    always @(negedge rst_b) model_reset(3);

    always @(posedge clk) begin
        if (rst_a === 1'b1) for (int i = 0; i < 3; i++) model_edge(i);
        if (rst_b === 1'b1) model_edge(3);
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut_res(i) !== mres[i]) begin
                failures++;
                $display("FAIL model_cmp dut%0d t=%0t got=%h exp=%h",
                         i, $time, dut_res(i), mres[i]);
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Randomised reset pulses on the hazard-heavy instance.
    initial begin
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        while (!done) begin
            @(posedge clk);
            #3 rst_b = 1'b1;
            repeat ($urandom_range(3, 60)) @(posedge clk);
            if ($urandom_range(0, 1) == 0) #2 rst_b = 1'b0;
            else                           #7 rst_b = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    end

    initial begin
        logic [31:0] exp0 [21];
        exp0 = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd5, 32'd10, 32'd15, 32'd10, 32'd5,
                 32'd10, 32'd15, 32'd15, 32'd15, 32'd15, 32'd15, 32'd15, 32'd15,
                 32'd15, 32'd15, 32'd15, 32'd5};
        rst_a = 1'b0;
        repeat (2) begin
            tick();
            check("reset_hold_dut0", bus0.result, 32'h0);
            check("reset_hold_dut1", bus1.result, 32'h0);
        end
        #2 rst_a = 1'b1;

        for (int e = 1; e <= 20; e++) begin
            tick();
            check($sformatf("dflt_edge%0d", e), bus0.result, exp0[e]);
            check($sformatf("r0_write_edge%0d", e), bus2.result, 32'h0);
            if (e == 4) check("ovr_addi_neg1", bus1.result, 32'hFFFF_FFFF);
            if (e == 5) check("ovr_add_fwd", bus1.result, 32'hFFFF_FFFE);
        end

        // Fresh run, then a reset pulse right after edge 7.
        rst_a = 1'b0;
        tick();
        #2 rst_a = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("rerun_edge%0d", e), bus0.result, exp0[e]);
        end
        rst_a = 1'b0;
        #1;
        check("midrun_reset_dut0", bus0.result, 32'h0);
        check("midrun_reset_dut1", bus1.result, 32'h0);
        @(posedge clk);
        #2 rst_a = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check($sformatf("after_reset_edge%0d", e), bus0.result, (e == 4) ? 32'd5 : 32'd0);
        end

        repeat (400) @(posedge clk);
        done = 1'b1;
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
